// File: rtl/spec_flag_gen.sv
// spec_flag_gen: source-side sequencer for the CCSDS-123 predictor.
// Accepts BIP-ordered samples over valid/ready, tracks the image-cube
// position (z fastest, then x, then y) and emits each accepted sample,
// one cycle later, with its position flags.
module spec_flag_gen #(
    parameter int DATA_WIDTH = 12,
    parameter int NX         = 16,
    parameter int NY         = 16,
    parameter int NZ         = 8,
    parameter int BLOCK_LEN  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  en_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  spec_fst_o,
    output logic                  en_block_cnt_o,
    output logic                  en_fst_blo_o,
    output logic                  last_o,
    output logic                  busy_o
);

    // Counter widths; a one-value extent still gets a 1-bit counter.
    localparam int ZW   = (NZ > 1) ? $clog2(NZ) : 1;
    localparam int XW   = (NX > 1) ? $clog2(NX) : 1;
    localparam int YW   = (NY > 1) ? $clog2(NY) : 1;
    localparam int BW   = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam int NTOT = NX * NY * NZ;
    localparam int IW   = $clog2(NTOT + 1);

    localparam logic [ZW-1:0] Z_MAX     = ZW'(NZ - 1);
    localparam logic [XW-1:0] X_MAX     = XW'(NX - 1);
    localparam logic [YW-1:0] Y_MAX     = YW'(NY - 1);
    localparam logic [BW-1:0] BLK_MAX   = BW'(BLOCK_LEN - 1);
    localparam logic [31:0]   BLK_LEN_U = 32'(BLOCK_LEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ZW-1:0]         z_q, z_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [BW-1:0]         blk_q, blk_d;
    logic [IW-1:0]         idx_q, idx_d;

    logic                  en_q, en_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  spec_fst_q, spec_fst_d;
    logic                  en_block_cnt_q, en_block_cnt_d;
    logic                  en_fst_blo_q, en_fst_blo_d;
    logic                  last_q, last_d;

    logic                  accept_s;
    logic                  last_s;

    // Handshake and frame-position decode from the current (pre-increment) counters.
    always_comb begin
        ready_o  = (state_q == ST_RUN);
        busy_o   = (state_q != ST_IDLE);
        accept_s = valid_i & ready_o;
        last_s   = (z_q == Z_MAX) && (x_q == X_MAX) && (y_q == Y_MAX);
    end

    // Frame sequencing: IDLE -> RUN on start, RUN -> DONE on the final accept, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Position counters: cleared on frame start, advanced only on an accepted sample.
    always_comb begin
        z_d   = z_q;
        x_d   = x_q;
        y_d   = y_q;
        blk_d = blk_q;
        idx_d = idx_q;
        if ((state_q == ST_IDLE) && start_i) begin
            z_d   = '0;
            x_d   = '0;
            y_d   = '0;
            blk_d = '0;
            idx_d = '0;
        end else if (accept_s) begin
            idx_d = idx_q + IW'(1'b1);
            if (blk_q == BLK_MAX) begin
                blk_d = '0;
            end else begin
                blk_d = blk_q + BW'(1'b1);
            end
            if (z_q == Z_MAX) begin
                z_d = '0;
                if (x_q == X_MAX) begin
                    x_d = '0;
                    if (y_q == Y_MAX) begin
                        y_d = '0;
                    end else begin
                        y_d = y_q + YW'(1'b1);
                    end
                end else begin
                    x_d = x_q + XW'(1'b1);
                end
            end else begin
                z_d = z_q + ZW'(1'b1);
            end
        end else begin
            z_d = z_q;
        end
    end

    // Output stage: capture sample and flags on accept, hold otherwise; en is a one-cycle pulse.
    always_comb begin
        en_d           = accept_s;
        data_d         = data_q;
        spec_fst_d     = spec_fst_q;
        en_block_cnt_d = en_block_cnt_q;
        en_fst_blo_d   = en_fst_blo_q;
        last_d         = last_q;
        if (accept_s) begin
            data_d         = data_i;
            spec_fst_d     = (z_q == '0);
            en_block_cnt_d = (blk_q == BLK_MAX) || last_s;
            en_fst_blo_d   = (32'(idx_q) < BLK_LEN_U);
            last_d         = last_s;
        end else begin
            data_d = data_q;
        end
    end

    // State, counter and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            z_q            <= '0;
            x_q            <= '0;
            y_q            <= '0;
            blk_q          <= '0;
            idx_q          <= '0;
            en_q           <= 1'b0;
            data_q         <= '0;
            spec_fst_q     <= 1'b0;
            en_block_cnt_q <= 1'b0;
            en_fst_blo_q   <= 1'b0;
            last_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            z_q            <= z_d;
            x_q            <= x_d;
            y_q            <= y_d;
            blk_q          <= blk_d;
            idx_q          <= idx_d;
            en_q           <= en_d;
            data_q         <= data_d;
            spec_fst_q     <= spec_fst_d;
            en_block_cnt_q <= en_block_cnt_d;
            en_fst_blo_q   <= en_fst_blo_d;
            last_q         <= last_d;
        end
    end

    assign en_o           = en_q;
    assign data_o         = data_q;
    assign spec_fst_o     = spec_fst_q;
    assign en_block_cnt_o = en_block_cnt_q;
    assign en_fst_blo_o   = en_fst_blo_q;
    assign last_o         = last_q;

endmodule

// File: tb/tb_spec_flag_gen.sv
// Scoreboard bench for spec_flag_gen: two instances (2x2x3 cube with
// 4-sample blocks, and a 5x1x1 line with 4-sample blocks). Drivers push
// hand-tabulated expectations; a negedge monitor pops them on en_o and
// checks that outputs hold between accepts.
module tb_spec_flag_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_start, a_valid, a_ready, a_en, a_spec, a_blk, a_fst, a_last, a_busy;
    logic [11:0] a_data, a_dout;
    logic        b_start, b_valid, b_ready, b_en, b_spec, b_blk, b_fst, b_last, b_busy;
    logic [11:0] b_data, b_dout;

    spec_flag_gen #(.DATA_WIDTH(12), .NX(2), .NY(2), .NZ(3), .BLOCK_LEN(4)) dut_a (
        .clk(clk), .rst(rst), .start_i(a_start), .valid_i(a_valid), .data_i(a_data),
        .ready_o(a_ready), .en_o(a_en), .data_o(a_dout), .spec_fst_o(a_spec),
        .en_block_cnt_o(a_blk), .en_fst_blo_o(a_fst), .last_o(a_last), .busy_o(a_busy)
    );

    spec_flag_gen #(.DATA_WIDTH(12), .NX(5), .NY(1), .NZ(1), .BLOCK_LEN(4)) dut_b (
        .clk(clk), .rst(rst), .start_i(b_start), .valid_i(b_valid), .data_i(b_data),
        .ready_o(b_ready), .en_o(b_en), .data_o(b_dout), .spec_fst_o(b_spec),
        .en_block_cnt_o(b_blk), .en_fst_blo_o(b_fst), .last_o(b_last), .busy_o(b_busy)
    );

    typedef struct packed {
        logic [11:0] data;
        logic        spec;
        logic        blk;
        logic        fst;
        logic        last;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ha, hb;
    int   checks   = 0;
    int   failures = 0;

    // Hand-computed flag tables, bit k = sample k+1.
    logic [11:0] spec_a_tab = 12'b0010_0100_1001;  // samples 1,4,7,10
    logic [11:0] blk_a_tab  = 12'b1000_1000_1000;  // samples 4,8,12
    logic [11:0] fst_a_tab  = 12'b0000_0000_1111;  // samples 1-4
    logic [11:0] last_a_tab = 12'b1000_0000_0000;  // sample 12
    logic [4:0]  spec_b_tab = 5'b11111;
    logic [4:0]  blk_b_tab  = 5'b11000;            // samples 4,5
    logic [4:0]  fst_b_tab  = 5'b01111;
    logic [4:0]  last_b_tab = 5'b10000;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: pop and compare on every en_o, otherwise outputs must hold.
    always @(negedge clk) begin
        exp_t got, e;
        if (rst) begin
            ha = '0;
            hb = '0;
        end else begin
            got = {a_dout, a_spec, a_blk, a_fst, a_last};
            checks++;
            if (a_en) begin
                if (qa.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_en_a: got %0h expected no output", got);
                    ha = got;
                end else begin
                    e = qa.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL sample_a: got %0h expected %0h", got, e);
                    end
                    ha = e;
                end
            end else if (got !== ha) begin
                failures++;
                $display("FAIL hold_a: got %0h expected %0h", got, ha);
            end
            got = {b_dout, b_spec, b_blk, b_fst, b_last};
            checks++;
            if (b_en) begin
                if (qb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_en_b: got %0h expected no output", got);
                    hb = got;
                end else begin
                    e = qb.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL sample_b: got %0h expected %0h", got, e);
                    end
                    hb = e;
                end
            end else if (got !== hb) begin
                failures++;
                $display("FAIL hold_b: got %0h expected %0h", got, hb);
            end
        end
    end

    // Pulse start for one cycle from a negedge; returns at the next negedge.
    task automatic do_start(input bit sel);
        if (sel) b_start = 1'b1; else a_start = 1'b1;
        @(negedge clk);
        if (sel) b_start = 1'b0; else a_start = 1'b0;
    endtask

    // Present sample i (1-based) from a negedge, wait for ready, push its expectation.
    task automatic send(input bit sel, input int i);
        int   n;
        exp_t e;
        logic rdy;
        if (sel) begin b_valid = 1'b1; b_data = 12'(i); end
        else     begin a_valid = 1'b1; a_data = 12'(i); end
        n = 0;
        rdy = sel ? b_ready : a_ready;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
            rdy = sel ? b_ready : a_ready;
        end
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 for sample %0d", i);
        end else begin
            e.data = 12'(i);
            if (sel) begin
                e.spec = spec_b_tab[i-1]; e.blk = blk_b_tab[i-1];
                e.fst  = fst_b_tab[i-1];  e.last = last_b_tab[i-1];
                qb.push_back(e);
            end else begin
                e.spec = spec_a_tab[i-1]; e.blk = blk_a_tab[i-1];
                e.fst  = fst_a_tab[i-1];  e.last = last_a_tab[i-1];
                qa.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        rst = 1'b1;
        a_start = 1'b0; a_valid = 1'b0; a_data = 12'd0;
        b_start = 1'b0; b_valid = 1'b0; b_data = 12'd0;
        repeat (2) @(negedge clk);
        chk("reset_a", {a_ready, a_en, a_dout, a_spec, a_blk, a_fst, a_last, a_busy}, 32'd0);
        chk("reset_b", {b_ready, b_en, b_dout, b_spec, b_blk, b_fst, b_last, b_busy}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);

        // Back-to-back 12-sample frame.
        chk("idle_ready_a", {31'd0, a_ready}, 32'd0);
        do_start(1'b0);
        chk("run_busy_a", {30'd0, a_busy, a_ready}, 32'd3);
        for (int i = 1; i <= 12; i++) send(1'b0, i);
        // valid held high into DONE: must not be accepted.
        chk("done_state_a", {30'd0, a_busy, a_ready}, 32'd2);
        @(negedge clk);
        chk("idle_after_done_a", {30'd0, a_busy, a_ready}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("idle_valid_ignored_a", {31'd0, a_ready}, 32'd0);
        end

        // Same frame, valid toggling every other cycle.
        do_start(1'b0);
        for (int i = 1; i <= 12; i++) begin
            send(1'b0, i);
            a_valid = 1'b0;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);

        // Short line with a partial final block.
        do_start(1'b1);
        for (int i = 1; i <= 5; i++) send(1'b1, i);
        b_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset abort after sample 6, then a fresh frame.
        do_start(1'b0);
        for (int i = 1; i <= 6; i++) send(1'b0, i);
        a_valid = 1'b0;
        #1 rst = 1'b1;
        #1 chk("abort_outputs_a", {a_ready, a_en, a_dout, a_spec, a_blk, a_fst, a_last, a_busy}, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        do_start(1'b0);
        for (int i = 1; i <= 12; i++) send(1'b0, i);
        a_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Two frames with start held high: ready low for exactly 2 cycles between.
        a_start = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 12; i++) send(1'b0, i);
        gap = 0;
        while (!a_ready && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        chk("interframe_gap_a", 32'(gap), 32'd2);
        for (int i = 1; i <= 12; i++) send(1'b0, i);
        a_start = 1'b0;
        a_valid = 1'b0;
        repeat (4) @(negedge clk);

        chk("queue_a_drained", 32'(qa.size()), 32'd0);
        chk("queue_b_drained", 32'(qb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spec_flag_gen.md
# spec_flag_gen

Source-side sequencer for the simplified CCSDS-123 predictor. It accepts raw samples over a valid/ready handshake in band-interleaved-by-pixel (BIP) order. For each accepted sample it emits one enable pulse, the registered sample, and the position flags that the downstream flag-delay stage re-times to the predictor's latency: first spectral band, block-count strobe, first-block marker and last-sample marker. It sits between the input sample interface and the predictor/flag-delay pipeline and owns all image-cube position counting.

## Interface
Parameters:
- DATA_WIDTH, 12, sample width in bits
- NX, 16, samples per line (x extent), ≥ 1
- NY, 16, lines per frame (y extent), ≥ 1
- NZ, 8, spectral bands (z extent), ≥ 1
- BLOCK_LEN, 64, samples per block for block-count strobes, ≥ 1

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  arms one frame; sampled only in IDLE
- valid_i  in  1  input sample valid
- data_i  in  DATA_WIDTH  input sample
- ready_o  out  1  block can accept a sample
- en_o  out  1  one-cycle pulse per accepted sample
- data_o  out  DATA_WIDTH  registered accepted sample
- spec_fst_o  out  1  sample is band z = 0
- en_block_cnt_o  out  1  sample closes a block
- en_fst_blo_o  out  1  sample lies in the frame's first block
- last_o  out  1  sample is the frame's final sample
- busy_o  out  1  frame in progress (state ≠ IDLE)

## Operation
- FSM has three states: IDLE, RUN, DONE.
  - IDLE → RUN when start_i = 1; all counters are cleared on this transition.
  - RUN → DONE on acceptance of the final sample (z = NZ−1, x = NX−1, y = NY−1).
  - DONE → IDLE unconditionally after one cycle.
  - start_i is ignored in RUN and DONE.
- ready_o = 1 only in RUN, decoded combinationally from state. Accept = valid_i & ready_o. valid_i outside RUN is ignored.
- Counters advance only on accept:
  - z_cnt (0..NZ−1) counts fastest and wraps to 0.
  - x_cnt increments on z wrap and wraps at NX−1.
  - y_cnt increments on x wrap.
  - Counter widths are $clog2 of the extent, minimum 1 bit.
- sample_idx counts accepted samples in the frame; its width covers NX·NY·NZ.
- blk_cnt (0..BLOCK_LEN−1) increments on accept, wraps to 0 at BLOCK_LEN−1, and is cleared on frame start.
- Flags are computed from the pre-increment counter values of the accepted sample:
  - spec_fst = (z_cnt == 0)
  - en_block_cnt = (blk_cnt == BLOCK_LEN−1) OR last sample. A partial final block still produces a strobe.
  - en_fst_blo = (sample_idx < BLOCK_LEN)
  - last = all three counters at maximum
- Output registers:
  - data_o and all flag outputs load only on accept and hold otherwise.
  - en_o is registered as accept, high for exactly one cycle per sample.
- NZ = 1: every sample has spec_fst = 1. BLOCK_LEN = 1: every sample strobes en_block_cnt, and only sample 0 has en_fst_blo.

## Timing
- Latency is 1 cycle from the accepting edge: en_o, data_o and the flags are valid together in the cycle after valid_i & ready_o.
- Throughput is 1 sample/cycle in RUN.
- ready_o falls in the cycle after the final accept (state = DONE). last_o and en_o for the final sample are high in that same DONE cycle.
- The earliest next frame: IDLE is reached 2 cycles after the final accept. A start_i in that IDLE cycle gives ready_o = 1 on the following cycle.
- Reset values: ready_o, en_o, spec_fst_o, en_block_cnt_o, en_fst_blo_o, last_o and busy_o are all 0; data_o = 0. State = IDLE and all counters are 0.
- Reset asserted mid-frame aborts immediately: all outputs take reset values asynchronously and no partial flags survive. The next frame requires a new start_i.
- start_i held high continuously re-arms the FSM on each IDLE cycle. A second start during RUN does not restart counters.

## Test plan
- Parameters NX=2, NY=2, NZ=3, BLOCK_LEN=4; start, then 12 back-to-back valid samples 1..12. Required response:
  - en_o is 12 single-cycle pulses, data_o = 1..12.
  - spec_fst_o = 1 on samples 1, 4, 7, 10.
  - en_block_cnt_o = 1 on samples 4, 8, 12.
  - en_fst_blo_o = 1 on samples 1–4.
  - last_o = 1 on sample 12 only.
- Same frame with valid_i toggling every other cycle: identical flag/data sequence. en_o occurs only on accept cycles, and outputs hold between them.
- NX=5, NY=1, NZ=1, BLOCK_LEN=4, 5 samples: spec_fst_o = 1 on all. en_block_cnt_o = 1 on samples 4 and 5 (partial block). last_o = 1 on sample 5.
- valid_i = 1 while IDLE and while DONE: no en_o, ready_o = 0, counters unchanged. A frame started afterwards begins with spec_fst_o = 1 and en_fst_blo_o = 1.
- Assert rst after sample 6 of the 12-sample frame: all outputs are 0 in the same cycle and busy_o = 0. After release plus start_i, the first sample has spec_fst_o = 1 and en_fst_blo_o = 1, and the counters restart at 0.
- Two frames back-to-back with start_i held high: ready_o is low for exactly 2 cycles between frames. Second-frame flags are identical to the first.
